// File: rtl/jts16_arb_pkg.sv
// Shared types and helpers for the jts16 SDRAM bank read arbiter.
package jts16_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam int DEF_SLOTS = 4;

    // Slot index width: $clog2(slots), but never narrower than one bit
    function automatic int idx_width(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/jts16_arb_slot.sv
// One client slot: a single-entry tag/data cache with hit compare and ok generation.
module jts16_arb_slot
    import jts16_arb_pkg::*;
#(
    parameter int AW = 22,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          inval,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill,
    input  logic [AW-1:0] fill_tag,
    input  logic [DW-1:0] fill_data,
    output logic          ok,
    output logic          miss,
    output logic [DW-1:0] data
);

    logic          valid_r;
    logic [AW-1:0] tag_r;
    logic [DW-1:0] data_r;
    logic          hit_s;

    // Cache entry: inval wins over a fill; the arbiter never fills in an inval cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r <= 1'b0;
            tag_r   <= '0;
            data_r  <= '0;
        end else begin
            if (inval) begin
                valid_r <= 1'b0;
            end else if (fill) begin
                valid_r <= 1'b1;
            end else begin
                valid_r <= valid_r;
            end
            if (fill) begin
                tag_r  <= fill_tag;
                data_r <= fill_data;
            end else begin
                tag_r  <= tag_r;
                data_r <= data_r;
            end
        end
    end

    // Hit/ok/miss are combinational so dropping cs clears ok in the same cycle
    always_comb begin
        hit_s = valid_r && (tag_r == addr);
        ok    = cs & hit_s;
        miss  = cs & ~hit_s;
    end

    assign data = data_r;

endmodule

// File: rtl/jts16_bank_arbiter.sv
// N-slot cached read arbiter for one SDRAM bank.
// Optional macro JTS16_ARB_RR_EN selects round-robin instead of fixed priority.
module jts16_bank_arbiter
    import jts16_arb_pkg::*;
#(
    parameter int SLOTS = DEF_SLOTS,
    parameter int AW    = 22,
    parameter int DW    = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                inval,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*DW-1:0] slot_data,
    output logic [AW-1:0]       ba_addr,
    output logic                ba_rd,
    input  logic                ba_ack,
    input  logic                ba_dok,
    input  logic                ba_rdy,
    input  logic [15:0]         data_read,
    output logic                busy
);

    localparam int IW = idx_width(SLOTS);

    arb_state_e      state_r, state_nx_s;
    logic [SLOTS-1:0] miss_s, fill_s;
    logic            grant_s, drop_r, ba_rd_r, busy_s;
    logic [IW-1:0]   win_s, win_r;
    logic [AW-1:0]   ba_addr_r;
    logic [DW-1:0]   buf_r, merged_s, fill_data_s;

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            jts16_arb_slot #(.AW(AW), .DW(DW)) u_slot (
                .clk       (clk),
                .rstn      (rstn),
                .inval     (inval),
                .cs        (slot_cs[gi]),
                .addr      (slot_addr[gi*AW +: AW]),
                .fill      (fill_s[gi]),
                .fill_tag  (ba_addr_r),
                .fill_data (fill_data_s),
                .ok        (slot_ok[gi]),
                .miss      (miss_s[gi]),
                .data      (slot_data[gi*DW +: DW])
            );
        end
    endgenerate

`ifdef JTS16_ARB_RR_EN
    logic [IW-1:0] ptr_r;

    // Round-robin pick: first missing slot at or after the pointer
    always_comb begin
        int idx_v;
        grant_s = 1'b0;
        win_s   = '0;
        idx_v   = 0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            idx_v = (int'(ptr_r) + k) % SLOTS;
            if (miss_s[idx_v]) begin
                grant_s = 1'b1;
                win_s   = IW'(idx_v);
            end else begin
                grant_s = grant_s;
                win_s   = win_s;
            end
        end
    end

    // Pointer advances past each granted slot
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r <= '0;
        end else if (state_r == IDLE && grant_s) begin
            ptr_r <= (win_s == IW'(SLOTS - 1)) ? '0 : win_s + IW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Fixed priority pick: lowest missing index wins
    always_comb begin
        grant_s = 1'b0;
        win_s   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (miss_s[i]) begin
                grant_s = 1'b1;
                win_s   = IW'(i);
            end else begin
                grant_s = grant_s;
                win_s   = win_s;
            end
        end
    end
`endif

    generate
        if (DW == 32) begin : g_w32
            logic wsel_r;

            // Word select: low word first, reset at each issue
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    wsel_r <= 1'b0;
                end else if (state_r == IDLE) begin
                    wsel_r <= 1'b0;
                end else if (state_r == DATA && ba_dok) begin
                    wsel_r <= ~wsel_r;
                end else begin
                    wsel_r <= wsel_r;
                end
            end

            // Merge the incoming word into the half selected by wsel_r
            always_comb begin
                merged_s = buf_r;
                if (wsel_r) begin
                    merged_s[DW-1:16] = data_read;
                end else begin
                    merged_s[15:0] = data_read;
                end
            end
        end else begin : g_w16
            // Single-word slots take the read word as-is
            always_comb begin
                merged_s = data_read;
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = grant_s ? REQ : IDLE;
            REQ:     state_nx_s = ba_ack ? DATA : REQ;
            DATA:    state_nx_s = ba_rdy ? IDLE : DATA;
            default: state_nx_s = IDLE;
        endcase
    end

    // Outputs and fill strobes; a fill seeing inval now or earlier is discarded
    always_comb begin
        busy_s      = (state_r != IDLE);
        fill_data_s = ba_dok ? merged_s : buf_r;
        for (int i = 0; i < SLOTS; i++) begin
            fill_s[i] = (state_r == DATA) && ba_rdy && !inval && !drop_r &&
                        (win_r == IW'(i));
        end
    end

    // Transaction datapath: issue latch, request handshake, data collection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ba_rd_r   <= 1'b0;
            ba_addr_r <= '0;
            win_r     <= '0;
            buf_r     <= '0;
            drop_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        ba_rd_r   <= 1'b1;
                        ba_addr_r <= slot_addr[win_s*AW +: AW];
                        win_r     <= win_s;
                        buf_r     <= '0;
                        drop_r    <= inval;
                    end else begin
                        ba_rd_r <= 1'b0;
                    end
                end
                REQ: begin
                    ba_rd_r <= ba_ack ? 1'b0 : 1'b1;
                    drop_r  <= drop_r | inval;
                end
                DATA: begin
                    if (ba_dok) begin
                        buf_r <= merged_s;
                    end else begin
                        buf_r <= buf_r;
                    end
                    drop_r <= drop_r | inval;
                end
                default: begin
                    ba_rd_r <= 1'b0;
                end
            endcase
        end
    end

    assign ba_rd   = ba_rd_r;
    assign ba_addr = ba_addr_r;
    assign busy    = busy_s;

endmodule

// File: tb/tb_jts16_bank_arbiter.sv
// Directed self-checking bench for jts16_bank_arbiter (16-bit 4-slot and 32-bit 2-slot instances).
module tb_jts16_bank_arbiter;

    logic        clk = 1'b0;
    logic        rstn, inval;
    logic [3:0]  slot_cs;
    logic [87:0] slot_addr;
    logic [3:0]  slot_ok;
    logic [63:0] slot_data;
    logic [21:0] ba_addr;
    logic        ba_rd, ba_ack, ba_dok, ba_rdy, busy;
    logic [15:0] data_read;

    logic [1:0]  cs_b, ok_b;
    logic [43:0] addr_b;
    logic [63:0] data_b;
    logic [21:0] ba_addr_b;
    logic        ba_rd_b, ack_b, dok_b, rdy_b, busy_b;
    logic [15:0] dread_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jts16_bank_arbiter #(.SLOTS(4), .AW(22), .DW(16)) u_dut (
        .clk(clk), .rstn(rstn), .inval(inval), .slot_cs(slot_cs),
        .slot_addr(slot_addr), .slot_ok(slot_ok), .slot_data(slot_data),
        .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dok(ba_dok),
        .ba_rdy(ba_rdy), .data_read(data_read), .busy(busy)
    );

    jts16_bank_arbiter #(.SLOTS(2), .AW(22), .DW(32)) u_dut32 (
        .clk(clk), .rstn(rstn), .inval(inval), .slot_cs(cs_b),
        .slot_addr(addr_b), .slot_ok(ok_b), .slot_data(data_b),
        .ba_addr(ba_addr_b), .ba_rd(ba_rd_b), .ba_ack(ack_b), .ba_dok(dok_b),
        .ba_rdy(rdy_b), .data_read(dread_b), .busy(busy_b)
    );

    // Wait (bounded) for ba_rd on the 16-bit instance
    task automatic wait_rd(output bit to);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ba_rd) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    // Act as the SDRAM controller for one single-word access
    task automatic bank_serve(input logic [15:0] d, output logic [21:0] a, output bit to);
        wait_rd(to);
        a = ba_addr;
        if (!to) begin
            ba_ack = 1'b1;
            @(posedge clk); #1;
            ba_ack = 1'b0;
            data_read = d; ba_dok = 1'b1; ba_rdy = 1'b1;
            @(posedge clk); #1;
            ba_dok = 1'b0; ba_rdy = 1'b0;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; inval = 1'b0; slot_cs = 4'd0; slot_addr = 88'd0;
        ba_ack = 1'b0; ba_dok = 1'b0; ba_rdy = 1'b0; data_read = 16'd0;
        cs_b = 2'd0; addr_b = 44'd0; ack_b = 1'b0; dok_b = 1'b0; rdy_b = 1'b0; dread_b = 16'd0;
        #1;
        n_tests++;
        if ({ba_rd, busy, slot_ok} !== 6'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got rd/busy/ok=%b required 0", {ba_rd, busy, slot_ok});
        end
        n_tests++;
        if (ba_addr !== 22'd0 || slot_data !== 64'd0) begin
            n_fail++; $display("FAIL reset_data: got addr=%h data=%h required 0", ba_addr, slot_data);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_first_miss;
        slot_addr[21:0] = 22'h000100; slot_cs = 4'b0001;
        @(posedge clk); #1;
        n_tests++;
        if (ba_rd !== 1'b1 || ba_addr !== 22'h000100 || busy !== 1'b1) begin
            n_fail++; $display("FAIL miss_issue: got rd=%b addr=%h busy=%b required 1/000100/1", ba_rd, ba_addr, busy);
        end
        @(posedge clk); #1;
        n_tests++;
        if (ba_rd !== 1'b1) begin
            n_fail++; $display("FAIL rd_hold: got %b required 1", ba_rd);
        end
        ba_ack = 1'b1;
        @(posedge clk); #1;
        ba_ack = 1'b0;
        n_tests++;
        if (ba_rd !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL ack_clear: got rd=%b busy=%b required 0/1", ba_rd, busy);
        end
        data_read = 16'hBEEF; ba_dok = 1'b1; ba_rdy = 1'b1;
        #1;
        n_tests++;
        if (slot_ok !== 4'b0000) begin
            n_fail++; $display("FAIL ok_early: got %b required 0000", slot_ok);
        end
        @(posedge clk); #1;
        ba_dok = 1'b0; ba_rdy = 1'b0;
        n_tests++;
        if (slot_ok !== 4'b0001 || slot_data[15:0] !== 16'hBEEF || busy !== 1'b0) begin
            n_fail++; $display("FAIL fill: got ok=%b data=%h busy=%b required 0001/beef/0", slot_ok, slot_data[15:0], busy);
        end
    endtask

    task automatic test_cache_hit;
        slot_cs = 4'b0000; #1;
        n_tests++;
        if (slot_ok !== 4'b0000) begin
            n_fail++; $display("FAIL cs_drop: got %b required 0000", slot_ok);
        end
        slot_cs = 4'b0001; #1;
        n_tests++;
        if (slot_ok !== 4'b0001) begin
            n_fail++; $display("FAIL hit_ok: got %b required 0001", slot_ok);
        end
        data_read = 16'hDEAD; ba_dok = 1'b1;
        @(posedge clk); #1;
        ba_dok = 1'b0;
        n_tests++;
        if (ba_rd !== 1'b0 || busy !== 1'b0 || slot_data[15:0] !== 16'hBEEF) begin
            n_fail++; $display("FAIL hit_quiet: got rd=%b busy=%b data=%h required 0/0/beef", ba_rd, busy, slot_data[15:0]);
        end
    endtask

    task automatic test_contention;
        logic [21:0] a;
        bit to;
        slot_addr[43:22] = 22'h000200; slot_addr[87:66] = 22'h000300; slot_cs = 4'b1010;
        bank_serve(16'h1111, a, to);
        n_tests++;
        if (to || a !== 22'h000200) begin
            n_fail++; $display("FAIL prio_first: got addr=%h timeout=%0d required 000200", a, to);
        end
        bank_serve(16'h3333, a, to);
        n_tests++;
        if (to || a !== 22'h000300) begin
            n_fail++; $display("FAIL prio_second: got addr=%h timeout=%0d required 000300", a, to);
        end
        n_tests++;
        if (slot_ok !== 4'b1010 || slot_data[63:48] !== 16'h3333 || slot_data[31:16] !== 16'h1111) begin
            n_fail++; $display("FAIL contention_fill: got ok=%b data=%h required 1010 3333/1111", slot_ok, slot_data);
        end
        slot_addr[21:0] = 22'h000400; slot_addr[87:66] = 22'h000500; slot_cs = 4'b1001;
        bank_serve(16'h4444, a, to);
        n_tests++;
        if (to || a !== 22'h000400) begin
            n_fail++; $display("FAIL slot0_first: got addr=%h timeout=%0d required 000400", a, to);
        end
        bank_serve(16'h5555, a, to);
        n_tests++;
        if (to || a !== 22'h000500 || slot_ok !== 4'b1001) begin
            n_fail++; $display("FAIL slot3_next: got addr=%h ok=%b required 000500/1001", a, slot_ok);
        end
    endtask

    task automatic test_addr_change;
        logic [21:0] a;
        bit to;
        slot_cs = 4'b0001; slot_addr[21:0] = 22'h000010;
        wait_rd(to);
        n_tests++;
        if (to || ba_addr !== 22'h000010) begin
            n_fail++; $display("FAIL chg_issue: got addr=%h timeout=%0d required 000010", ba_addr, to);
        end
        ba_ack = 1'b1;
        @(posedge clk); #1;
        ba_ack = 1'b0;
        slot_addr[21:0] = 22'h000020;
        data_read = 16'hAAAA; ba_dok = 1'b1; ba_rdy = 1'b1;
        @(posedge clk); #1;
        ba_dok = 1'b0; ba_rdy = 1'b0;
        n_tests++;
        if (slot_ok[0] !== 1'b0) begin
            n_fail++; $display("FAIL chg_stale_ok: got %b required 0", slot_ok[0]);
        end
        bank_serve(16'hBBBB, a, to);
        n_tests++;
        if (to || a !== 22'h000020 || slot_ok[0] !== 1'b1 || slot_data[15:0] !== 16'hBBBB) begin
            n_fail++; $display("FAIL chg_refetch: got addr=%h ok=%b data=%h required 000020/1/bbbb", a, slot_ok[0], slot_data[15:0]);
        end
    endtask

    task automatic test_inval;
        logic [21:0] a;
        bit to;
        slot_addr[21:0] = 22'h000030;
        wait_rd(to);
        ba_ack = 1'b1;
        @(posedge clk); #1;
        ba_ack = 1'b0;
        inval = 1'b1; data_read = 16'hCCCC; ba_dok = 1'b1;
        @(posedge clk); #1;
        inval = 1'b0; data_read = 16'hCCCD; ba_rdy = 1'b1;
        @(posedge clk); #1;
        ba_dok = 1'b0; ba_rdy = 1'b0;
        n_tests++;
        if (to || slot_ok !== 4'b0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL inval_discard: got ok=%b busy=%b timeout=%0d required 0000/0", slot_ok, busy, to);
        end
        bank_serve(16'hCCCE, a, to);
        n_tests++;
        if (to || a !== 22'h000030 || slot_ok[0] !== 1'b1 || slot_data[15:0] !== 16'hCCCE) begin
            n_fail++; $display("FAIL inval_reissue: got addr=%h ok=%b data=%h required 000030/1/ccce", a, slot_ok[0], slot_data[15:0]);
        end
        slot_cs = 4'b0000; inval = 1'b1;
        @(posedge clk); #1;
        inval = 1'b0; slot_cs = 4'b0001; #1;
        n_tests++;
        if (slot_ok[0] !== 1'b0) begin
            n_fail++; $display("FAIL inval_idle: got %b required 0", slot_ok[0]);
        end
        bank_serve(16'hCCCF, a, to);
        n_tests++;
        if (to || a !== 22'h000030 || slot_ok[0] !== 1'b1) begin
            n_fail++; $display("FAIL inval_refill: got addr=%h ok=%b required 000030/1", a, slot_ok[0]);
        end
    endtask

    task automatic test_dw32;
        bit to;
        cs_b = 2'b01; addr_b[21:0] = 22'h000040;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ba_rd_b) begin
                to = 1'b0;
                break;
            end
        end
        n_tests++;
        if (to || ba_addr_b !== 22'h000040) begin
            n_fail++; $display("FAIL w32_issue: got addr=%h timeout=%0d required 000040", ba_addr_b, to);
        end
        ack_b = 1'b1;
        @(posedge clk); #1;
        ack_b = 1'b0; dread_b = 16'h1234; dok_b = 1'b1;
        @(posedge clk); #1;
        dread_b = 16'h5678; rdy_b = 1'b1;
        @(posedge clk); #1;
        dok_b = 1'b0; rdy_b = 1'b0;
        n_tests++;
        if (ok_b !== 2'b01 || data_b[31:0] !== 32'h56781234) begin
            n_fail++; $display("FAIL w32_fill: got ok=%b data=%h required 01/56781234", ok_b, data_b[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_cache_hit();
        test_contention();
        test_addr_change();
        test_inval();
        test_dw32();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
